// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO fabric.
// Holds the FSM state enum, error data and decode helpers.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mmio_state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_fabric_if.sv
// Slave-side bus of the MMIO fabric: one-hot req, broadcast we/addr/wdata,
// flattened per-slave rdata and per-slave ack.
interface mmio_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [NUM_SLAVES-1:0] req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NUM_SLAVES*DATA_W-1:0] rdata;
  logic [NUM_SLAVES-1:0] ack;

  modport master (
    output req, we, addr, wdata,
    input rdata, ack
  );

  modport slave (
    input req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mmio_decoder.sv
// Combinational address decode: MMIO window match and slave index.
// in: dataadr; out: sel (0 outside the window).
module mmio_decoder
  import mmio_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter int SEL_LSB = 8,
  parameter int NUM_SLAVES = 4,
  localparam int SW = sel_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] dataadr,
  output logic [SW-1:0]     sel
);

  logic hit;
  logic unused;

  assign hit = dataadr[ADDR_W-1 -: 16] == MMIO_BASE[31:16];
  assign sel = hit ? dataadr[SEL_LSB +: SW] : '0;
  assign unused = ^dataadr;

endmodule

// File: rtl/mmio_fabric.sv
// MMIO interconnect: core data port to N req/ack slaves with timeout.
// Ports: core strobes/addr/data, stall, slave bus (master modport), err status.
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              stall,
  mmio_fabric_if.master     bus,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);

  localparam int SW = sel_w(NUM_SLAVES);
  localparam int CW = 8;

  mmio_state_t state_q, state_d;

  logic [SW-1:0] sel, sel_q;
  logic [CW-1:0] cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [NUM_SLAVES-1:0] req_q;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic eflag_q;
  logic [ADDR_W-1:0] eaddr_q;

  logic access, start, ack_hit, tmo;
  logic done_ack, done_tmo;

  mmio_decoder #(
    .ADDR_W(ADDR_W),
    .MMIO_BASE(MMIO_BASE),
    .SEL_LSB(SEL_LSB),
    .NUM_SLAVES(NUM_SLAVES)
  ) u_dec (
    .dataadr(dataadr),
    .sel(sel)
  );

  assign access = memwrite | memread;
  assign start = (state_q == IDLE) & access;
  assign ack_hit = bus.ack[sel_q];
  // Counter value one short of TIMEOUT means this WAIT cycle is the last.
  assign tmo = cnt_q == CW'(TIMEOUT - 1);
  assign done_ack = (state_q == WAIT) & ack_hit;
  assign done_tmo = (state_q == WAIT) & ~ack_hit & tmo;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access) state_d = WAIT;
      WAIT: if (ack_hit || tmo) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      req_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (start) begin
        sel_q <= sel;
        addr_q <= dataadr;
        wdata_q <= writedata;
        we_q <= memwrite;
        req_q <= NUM_SLAVES'(1) << sel;
        cnt_q <= '0;
      end
      if (done_ack) begin
        rdata_q <= we_q ? '0
          : bus.rdata[int'(sel_q)*DATA_W +: DATA_W];
        req_q <= '0;
      end else if (state_q == WAIT) begin
        if (cnt_q != CW'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
        if (tmo) begin
          req_q <= '0;
          rdata_q <= DATA_W'(ERR_DATA);
        end
      end
    end
  end

  // err_clr wins over a timeout completing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eflag_q <= 1'b0;
      eaddr_q <= '0;
    end else if (err_clr) begin
      eflag_q <= 1'b0;
      eaddr_q <= '0;
    end else if (done_tmo && !eflag_q) begin
      eflag_q <= 1'b1;
      eaddr_q <= addr_q;
    end
  end

  assign stall = access & (state_q != DONE);
  assign readdata = rdata_q;
  assign err_flag = eflag_q;
  assign err_addr = eaddr_q;
  assign bus.req = req_q;
  assign bus.we = we_q;
  assign bus.addr = addr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed self-checking bench for mmio_fabric.
// Drives inputs on negedge, samples 1ns later.
module tb_mmio_fabric;

  logic clk = 1'b0;
  logic reset;
  logic memwrite, memread;
  logic [31:0] dataadr, writedata;
  logic [31:0] readdata;
  logic stall;
  logic err_flag;
  logic [31:0] err_addr;
  logic err_clr;

  int nchk = 0;
  int nfail = 0;

  logic [3:0] req0, req1;
  logic we1;
  logic [31:0] addr1, wdata1;
  int stalls;
  logic [31:0] rd;

  mmio_fabric_if #(.NUM_SLAVES(4), .DATA_W(32), .ADDR_W(32)) bus ();

  mmio_fabric dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .memread(memread),
    .dataadr(dataadr),
    .writedata(writedata),
    .readdata(readdata),
    .stall(stall),
    .bus(bus),
    .err_flag(err_flag),
    .err_addr(err_addr),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack from slave slv in WAIT cycle k (0 = never); optional spurious
  // ack bit sp_slv in cycle sp_cyc (cycle 0 is the IDLE cycle).
  function automatic logic [3:0] ackv(input int c, input int slv,
                                      input int k, input int sp_cyc,
                                      input int sp_slv);
    logic [3:0] v;
    v = '0;
    if (k != 0 && c == k) v[slv] = 1'b1;
    if (c == sp_cyc) v[sp_slv] = 1'b1;
    return v;
  endfunction

  task automatic access(input logic wr, input logic both,
                        input logic [31:0] adr, input logic [31:0] wd,
                        input int slv, input int k,
                        input logic [31:0] sdata,
                        input int sp_cyc, input int sp_slv);
    int cyc;
    @(negedge clk);
    memwrite = wr;
    memread = !wr || both;
    dataadr = adr;
    writedata = wd;
    for (int i = 0; i < 4; i++)
      bus.rdata[i*32 +: 32] = 32'h5A5A_0000 | i;
    bus.rdata[slv*32 +: 32] = sdata;
    bus.ack = ackv(0, slv, k, sp_cyc, sp_slv);
    #1;
    req0 = bus.req;
    stalls = 0;
    cyc = 0;
    while (stall === 1'b1 && cyc < 300) begin
      stalls++;
      @(negedge clk);
      cyc++;
      bus.ack = ackv(cyc, slv, k, sp_cyc, sp_slv);
      #1;
      if (cyc == 1) begin
        req1 = bus.req;
        we1 = bus.we;
        addr1 = bus.addr;
        wdata1 = bus.wdata;
      end
    end
    if (cyc >= 300) chk("stall_bound", 64'(cyc), 64'd0);
    rd = readdata;
    bus.ack = '0;
  endtask

  task automatic idle();
    @(negedge clk);
    memwrite = 1'b0;
    memread = 1'b0;
    bus.ack = '0;
  endtask

  initial begin
    reset = 1'b1;
    memwrite = 1'b0;
    memread = 1'b0;
    dataadr = '0;
    writedata = '0;
    err_clr = 1'b0;
    bus.rdata = '0;
    bus.ack = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.req, 4'b0000);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_eflag", err_flag, 1'b0);
    chk("rst_eaddr", err_addr, 32'h0);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // RAM read, immediate ack
    access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 1,
           32'h1234_5678, -1, 0);
    chk("ram_req", req1, 4'b0001);
    chk("ram_addr", addr1, 32'h0000_0040);
    chk("ram_stall", 64'(stalls), 64'd2);
    chk("ram_rd", rd, 32'h1234_5678);
    idle();

    // MMIO write with both strobes high, ack after 4 cycles
    access(1'b1, 1'b1, 32'hFFFF_0200, 32'h0000_00FF, 2, 4,
           32'hCAFE_0002, -1, 0);
    chk("wr_req", req1, 4'b0100);
    chk("wr_we", we1, 1'b1);
    chk("wr_wdata", wdata1, 32'h0000_00FF);
    chk("wr_stall", 64'(stalls), 64'd5);
    chk("wr_rd", rd, 32'h0);
    idle();

    // Outside the window maps to slave 0
    access(1'b0, 1'b0, 32'hFFFE_0300, 32'h0, 0, 1,
           32'h0BAD_F00D, -1, 0);
    chk("win_req", req1, 4'b0001);
    chk("win_rd", rd, 32'h0BAD_F00D);
    idle();

    // Ack on the last possible cycle wins over timeout
    access(1'b0, 1'b0, 32'hFFFF_0300, 32'h0, 3, 15,
           32'h3333_3333, -1, 0);
    chk("late_stall", 64'(stalls), 64'd16);
    chk("late_rd", rd, 32'h3333_3333);
    chk("late_eflag", err_flag, 1'b0);
    idle();

    // Timeout
    access(1'b0, 1'b0, 32'hFFFF_0300, 32'h0, 3, 0,
           32'h3333_3333, -1, 0);
    chk("to_stall", 64'(stalls), 64'd16);
    chk("to_rd", rd, 32'hDEAD_BEEF);
    chk("to_eflag", err_flag, 1'b1);
    chk("to_eaddr", err_addr, 32'hFFFF_0300);
    chk("to_req_drop", bus.req, 4'b0000);
    idle();

    // Second timeout keeps the first address
    access(1'b0, 1'b0, 32'hFFFF_0100, 32'h0, 1, 0,
           32'h1111_1111, -1, 0);
    chk("to2_eflag", err_flag, 1'b1);
    chk("to2_eaddr", err_addr, 32'hFFFF_0300);
    idle();

    err_clr = 1'b1;
    @(negedge clk);
    #1;
    chk("clr_eflag", err_flag, 1'b0);
    chk("clr_eaddr", err_addr, 32'h0);

    // Timeout while err_clr held is lost
    access(1'b0, 1'b0, 32'hFFFF_0200, 32'h0, 2, 0,
           32'h2222_2222, -1, 0);
    chk("clrpri_eflag", err_flag, 1'b0);
    chk("clrpri_rd", rd, 32'hDEAD_BEEF);
    idle();
    err_clr = 1'b0;

    // Spurious ack from slave 3 while slave 1 selected
    access(1'b0, 1'b0, 32'hFFFF_0100, 32'h0, 1, 3,
           32'h1010_1010, 1, 3);
    chk("sp3_req", req1, 4'b0010);
    chk("sp3_stall", 64'(stalls), 64'd4);
    chk("sp3_rd", rd, 32'h1010_1010);
    idle();

    // Ack from slave 1 in the IDLE cycle is ignored
    access(1'b0, 1'b0, 32'hFFFF_0100, 32'h0, 1, 2,
           32'h2020_2020, 0, 1);
    chk("spi_stall", 64'(stalls), 64'd3);
    chk("spi_rd", rd, 32'h2020_2020);
    idle();

    // Reset in the 2nd WAIT cycle
    @(negedge clk);
    memread = 1'b1;
    dataadr = 32'hFFFF_0100;
    @(negedge clk);
    #1;
    chk("rw_req1", bus.req, 4'b0010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw_req", bus.req, 4'b0000);
    chk("rw_stall_hi", stall, 1'b1);
    chk("rw_rdata", readdata, 32'h0);
    memread = 1'b0;
    #1;
    chk("rw_stall_lo", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 1'b0, 32'hFFFF_0200, 32'h0, 2, 1,
           32'h4444_4444, -1, 0);
    chk("rw_next_req", req1, 4'b0100);
    chk("rw_next_stall", 64'(stalls), 64'd2);
    chk("rw_next_rd", rd, 32'h4444_4444);
    idle();

    // Back-to-back reads
    access(1'b0, 1'b0, 32'hFFFF_0100, 32'h0, 1, 1,
           32'hB2B0_0001, -1, 0);
    chk("b2b1_req", req1, 4'b0010);
    chk("b2b1_rd", rd, 32'hB2B0_0001);
    access(1'b0, 1'b0, 32'hFFFF_0200, 32'h0, 2, 1,
           32'hB2B0_0002, -1, 0);
    chk("b2b2_req0", req0, 4'b0000);
    chk("b2b2_req", req1, 4'b0100);
    chk("b2b2_stall", 64'(stalls), 64'd2);
    chk("b2b2_rd", rd, 32'hB2B0_0002);
    idle();
    @(negedge clk);
    #1;
    chk("hold_rd", readdata, 32'hB2B0_0002);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mmio_fabric.md
# mmio_fabric

Parametrised memory-mapped I/O interconnect between the single-cycle MIPS core's data port and up to `NUM_SLAVES` peripherals (data RAM, LED register, ADC, seven-segment, ...). It generalises the fixed memory map to N decoded regions with a per-slave req/ack handshake. Accesses stall the core until the selected slave acknowledges or a timeout fires. Timed-out accesses are recorded in a sticky error status.

## Interface
Parameters:
- `NUM_SLAVES`, 4, number of slave ports (2..16); slave 0 is the default (RAM) target.
- `DATA_W`, 32, data width.
- `ADDR_W`, 32, address width.
- `MMIO_BASE`, 32'hFFFF_0000, MMIO window base; the window is the 64 KiB region whose `addr[31:16]` equals `MMIO_BASE[31:16]`.
- `SEL_LSB`, 8, lowest address bit of the slave index field.
- `TIMEOUT`, 15, maximum WAIT cycles before an access is aborted (1..255).

Ports:
- `clk`, in, 1, system clock.
- `reset`, in, 1, asynchronous, active-high.
- `memwrite`, in, 1, core write strobe.
- `memread`, in, 1, core read strobe.
- `dataadr`, in, ADDR_W, core byte address.
- `writedata`, in, DATA_W, core write data.
- `readdata`, out, DATA_W, read data to core; valid in DONE.
- `stall`, out, 1, freezes PC and writeback while high.
- `s_req`, out, NUM_SLAVES, one-hot request; held until ack or timeout.
- `s_we`, out, 1, write qualifier, broadcast to all slaves.
- `s_addr`, out, ADDR_W, registered address, broadcast.
- `s_wdata`, out, DATA_W, registered write data, broadcast.
- `s_rdata`, in, NUM_SLAVES*DATA_W, flattened slave read data; slave i occupies `[i*DATA_W +: DATA_W]`.
- `s_ack`, in, NUM_SLAVES, per-slave acknowledge.
- `err_flag`, out, 1, sticky timeout flag.
- `err_addr`, out, ADDR_W, address of the first timed-out access.
- `err_clr`, in, 1, clears `err_flag` and `err_addr`.

## Operation
- Access: `memwrite | memread`. If both are high, the access is a write.
- Decode:
  - Inside the MMIO window: `sel = dataadr[SEL_LSB +: $clog2(NUM_SLAVES)]`.
  - Outside the window: `sel = 0`.
- FSM states: IDLE, WAIT, DONE.
- IDLE, on access:
  - Register `sel`, `dataadr`, `writedata` and the write flag.
  - Set `s_req[sel]`.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT, on `s_ack[sel]`:
  - Capture `s_rdata[sel]` into the read register; writes capture 0.
  - Drop `s_req`.
  - Go to DONE.
- WAIT, with no ack:
  - Increment the counter.
  - When the counter reaches `TIMEOUT`, drop `s_req` and load `ERR_DATA` (32'hDEAD_BEEF) into the read register.
  - If `err_flag` is low, set `err_flag` and latch `err_addr`.
  - Go to DONE.
- DONE: always go to IDLE on the next cycle.
- `stall = access & (state != DONE)`, combinational. The core holds `dataadr` and the strobes stable while stalled; the fabric does not re-sample them in WAIT.
- `readdata` = read register; it holds its value outside DONE.
- Acks from non-selected slaves, and any ack in IDLE or DONE, are ignored.
- An ack on the same cycle the counter reaches `TIMEOUT` counts as an ack, not a timeout.
- `err_clr` has priority over a simultaneous new timeout; that timeout is lost.
- Reset values:
  - state IDLE, counter 0;
  - `s_req` 0, `s_we` 0, `s_addr` 0, `s_wdata` 0;
  - read register 0;
  - `err_flag` 0, `err_addr` 0.
- Reset mid-WAIT drops `s_req` immediately; the pending access is abandoned.

## Timing
- Every access stalls for a minimum of 2 cycles: IDLE→WAIT, then an ack in the first WAIT cycle.
- Total access time is 3 cycles, including the DONE cycle in which `stall` = 0 and the core retires.
- A slave acking k cycles after `s_req` rises gives k+1 stall cycles.
- Timeout gives `TIMEOUT`+1 stall cycles.
- `s_req`, `s_we`, `s_addr` and `s_wdata` are registered; slaves see no combinational path from the core.
- A back-to-back access (next instruction) starts in the IDLE cycle following DONE.
- The counter saturates at `TIMEOUT`; it never wraps.

## Structure
- `mmio_pkg` holds:
  - the state enum `mmio_state_t` {IDLE, WAIT, DONE};
  - `ERR_DATA`;
  - the default `MMIO_BASE`;
  - the function `sel_w(n) = $clog2(n)`.
- Sub-module `mmio_decoder`: combinational window match and slave index from `dataadr`, parametrised by `MMIO_BASE`, `SEL_LSB` and `NUM_SLAVES`.

## Test plan
- **RAM read:** read 32'h0000_0040 with slave 0 acking in the first WAIT cycle and `s_rdata[0]` = 32'h1234_5678. Expect `s_req` = 4'b0001, `stall` high for 2 cycles, `readdata` = 32'h1234_5678 in DONE.
- **MMIO write:** write 32'h0000_00FF to 32'hFFFF_0200 with slave 2 acking after 4 cycles. Expect `s_req` = 4'b0100, `s_we` = 1, `s_wdata` = 32'h0000_00FF, 5 stall cycles.
- **Timeout:** read 32'hFFFF_0300 with no ack and `TIMEOUT` = 15. Expect 16 stall cycles, `readdata` = 32'hDEAD_BEEF, `err_flag` = 1, `err_addr` = 32'hFFFF_0300. A second timeout at 32'hFFFF_0100 leaves `err_addr` unchanged. `err_clr` then clears both.
- **Spurious acks:** `s_ack[3]` pulsed while slave 1 is selected, and `s_ack[1]` pulsed in IDLE. Expect both ignored and the access to complete only on the real `s_ack[1]`.
- **Reset mid-WAIT:** assert `reset` in the 2nd WAIT cycle. Expect `s_req` = 0 and `stall` to depend only on the strobes with state IDLE. The next access proceeds normally.
- **Back-to-back:** two consecutive reads to slaves 1 and 2, both with immediate ack. Expect the second `s_req` to rise exactly one cycle after DONE, with each `readdata` correct.
